// File: rtl/io_matrix_ctrl.sv
// io_matrix_ctrl: an I/O-space peripheral on the CPU's shared address/data bus.
// It holds an 8x8 LED framebuffer and scans it one row at a time onto a
// row_n/col matrix. It also debounces four player buttons and gives the CPU
// their live levels and sticky press events.
//
// CPU handshake: a port is selected when mem_io is high and addr_bus falls in
// IO_BASE..IO_BASE+4. A write commits on the single clk where mem_clk rises
// with c_ri high. A read drives the bus combinationally for as long as c_ro is
// high. The read side effect (clearing the press events) happens on the clk
// where mem_clk rises with c_ro high.
module io_matrix_ctrl #(
    parameter logic [7:0] IO_BASE  = 8'h00,
    parameter int         SCAN_DIV = 1000,
    parameter int         DEBOUNCE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] addr_bus,
    input  logic       c_ri,
    input  logic       c_ro,
    input  logic       mem_clk,
    input  logic       mem_io,
    inout  wire  [7:0] bus,
    input  logic [3:0] btn,
    output logic [7:0] row_n,
    output logic [7:0] col
);

    localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int DB_W  = (DEBOUNCE > 2) ? $clog2(DEBOUNCE) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE - 1);

    localparam logic [2:0] P_ROW_SEL   = 3'd0;
    localparam logic [2:0] P_ROW_DATA  = 3'd1;
    localparam logic [2:0] P_BTN_LEVEL = 3'd2;
    localparam logic [2:0] P_BTN_EVENT = 3'd3;
    localparam logic [2:0] P_CTRL      = 3'd4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    // Reset: asserts asynchronously, releases on a clk edge
    logic [1:0] rst_sync;
    logic       rst_n;

    // CPU-side decode
    logic [7:0] port_off;
    logic       sel;
    logic [2:0] port;
    logic       mem_clk_q;
    logic       mem_clk_rise;
    logic       wr;
    logic       evt_clr;
    logic [7:0] rd_data;

    // Framebuffer and control
    state_t     state;
    logic [7:0] fb [8];
    logic [2:0] row_ptr;
    logic [2:0] clr_idx;
    logic       disp_en;
    logic       busy;

    // Scanner
    logic [DIV_W-1:0] div;
    logic [2:0]       scan_row;

    // Buttons
    logic [3:0]      btn_meta;
    logic [3:0]      btn_sync;
    logic [3:0]      btn_db;
    logic [DB_W-1:0] db_cnt [4];
    logic [3:0]      db_accept;
    logic [3:0]      db_rise;
    logic [3:0]      evt;

    // Two-flop reset synchronizer: rst_n drops with reset, rises two clks after release
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n = rst_sync[1];

    // Address decode. The subtraction wraps, so addresses below IO_BASE land far above 4.
    assign port_off = addr_bus - IO_BASE;
    assign sel      = mem_io & (port_off < 8'd5);
    assign port     = port_off[2:0];

    // Register the CPU memory clock phase to find its rising edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_clk_q <= 1'b0;
        end else begin
            mem_clk_q <= mem_clk;
        end
    end

    assign mem_clk_rise = mem_clk & ~mem_clk_q;
    assign wr           = sel & c_ri & mem_clk_rise;
    assign evt_clr      = sel & c_ro & (port == P_BTN_EVENT) & mem_clk_rise;

    // Read-data mux for the selected port
    always_comb begin
        rd_data = 8'h00;
        case (port)
            P_ROW_SEL:   rd_data = {5'b0, row_ptr};
            P_ROW_DATA:  rd_data = fb[row_ptr];
            P_BTN_LEVEL: rd_data = {4'b0, btn_db};
            P_BTN_EVENT: rd_data = {4'b0, evt};
            P_CTRL:      rd_data = {6'b0, busy, disp_en};
            default:     rd_data = 8'h00;
        endcase
    end

    // Only drive the shared bus during a selected I/O read and never while in reset
    assign bus = (rst_n && sel && c_ro) ? rd_data : 8'bz;

    // Control FSM: CPU writes to the framebuffer and control, plus the 8-clk clear sweep
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            row_ptr <= 3'd0;
            clr_idx <= 3'd0;
            disp_en <= 1'b0;
            busy    <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                fb[i] <= 8'h00;
            end
        end else begin
            // disp_en can be changed in any state; bit1 only matters from IDLE
            if (wr && port == P_CTRL) begin
                disp_en <= bus[0];
            end
            case (state)
                ST_IDLE: begin
                    if (wr && port == P_ROW_SEL) begin
                        row_ptr <= bus[2:0];
                    end else if (wr && port == P_ROW_DATA) begin
                        fb[row_ptr] <= bus;
                        row_ptr     <= row_ptr + 3'd1;
                    end else if (wr && port == P_CTRL && bus[1]) begin
                        state   <= ST_CLEAR;
                        busy    <= 1'b1;
                        clr_idx <= 3'd0;
                    end
                end
                ST_CLEAR: begin
                    // Row writes are dropped here; each clk zeroes one row
                    fb[clr_idx] <= 8'h00;
                    clr_idx     <= clr_idx + 3'd1;
                    if (clr_idx == 3'd7) begin
                        state   <= ST_IDLE;
                        busy    <= 1'b0;
                        row_ptr <= 3'd0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Scanner: divider and row counter run freely; outputs are registered, with a blank on div == 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div      <= '0;
            scan_row <= 3'd0;
            row_n    <= 8'hFF;
            col      <= 8'h00;
        end else begin
            if (div == DIV_LAST) begin
                div      <= '0;
                scan_row <= scan_row + 3'd1;
            end else begin
                div <= div + DIV_W'(1);
            end
            if (!disp_en || div == '0) begin
                row_n <= 8'hFF;
                col   <= 8'h00;
            end else begin
                row_n <= ~(8'd1 << scan_row);
                col   <= fb[scan_row];
            end
        end
    end

    // Two-flop synchronizer for the asynchronous raw buttons
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_meta <= 4'b0;
            btn_sync <= 4'b0;
        end else begin
            btn_meta <= btn;
            btn_sync <= btn_meta;
        end
    end

    // A button flips on the DEBOUNCE-th consecutive sample that differs from its debounced level
    always_comb begin
        db_accept = 4'b0;
        db_rise   = 4'b0;
        for (int i = 0; i < 4; i++) begin
            db_accept[i] = (btn_sync[i] != btn_db[i]) && (db_cnt[i] == DB_LAST);
            db_rise[i]   = db_accept[i] & btn_sync[i];
        end
    end

    // Debounce counters, debounced levels and sticky events (a new press beats a same-clk read-clear)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_db <= 4'b0;
            evt    <= 4'b0;
            for (int i = 0; i < 4; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (btn_sync[i] == btn_db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_accept[i]) begin
                    btn_db[i] <= btn_sync[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
            evt <= (evt_clr ? 4'b0 : evt) | db_rise;
        end
    end

endmodule

// File: tb/tb_io_matrix_ctrl.sv
// Bench for io_matrix_ctrl: CPU bus driver tasks, a port-level reference model
// of the framebuffer/control/button registers, and a time-based model of the
// scanner that counts clks from reset release.
`timescale 1ns/1ps
module tb_io_matrix_ctrl;

  localparam logic [7:0] IO_BASE = 8'h10;
  localparam int SCAN_DIV = 4;
  localparam int DEBOUNCE = 16;

  logic       clk;
  logic       reset;
  logic [7:0] addr_bus;
  logic       c_ri;
  logic       c_ro;
  logic       mem_clk;
  logic       mem_io;
  wire  [7:0] bus;
  logic [3:0] btn;
  logic [7:0] row_n;
  logic [7:0] col;

  logic [7:0] tb_bus;
  logic       tb_drv;
  assign bus = tb_drv ? tb_bus : 8'bz;

  io_matrix_ctrl #(
    .IO_BASE (IO_BASE),
    .SCAN_DIV(SCAN_DIV),
    .DEBOUNCE(DEBOUNCE)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .addr_bus(addr_bus),
    .c_ri    (c_ri),
    .c_ro    (c_ro),
    .mem_clk (mem_clk),
    .mem_io  (mem_io),
    .bus     (bus),
    .btn     (btn),
    .row_n   (row_n),
    .col     (col)
  );

  // clock / reset-relative cycle count
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1);
  end

  // scoreboard and reference model
  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];

  logic [7:0] fb_m [8];
  logic [2:0] rp_m;
  logic       disp_en_m;
  logic       busy_m;
  logic [3:0] lvl_m;
  logic [3:0] evt_m;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) fb_m[i] = 8'h00;
    rp_m = 3'd0;
    disp_en_m = 1'b0;
    busy_m = 1'b0;
    lvl_m = 4'b0;
    evt_m = 4'b0;
  endtask

  task automatic model_write(input logic [2:0] p, input logic [7:0] d);
    case (p)
      3'd0: rp_m = d[2:0];
      3'd1: begin fb_m[rp_m] = d; rp_m = rp_m + 3'd1; end
      3'd4: begin
        disp_en_m = d[0];
        if (d[1]) begin
          for (int i = 0; i < 8; i++) fb_m[i] = 8'h00;
          rp_m = 3'd0;
        end
      end
      default: ;
    endcase
  endtask

  task automatic model_read(input logic [2:0] p, output logic [7:0] d);
    case (p)
      3'd0: d = {5'b0, rp_m};
      3'd1: d = fb_m[rp_m];
      3'd2: d = {4'b0, lvl_m};
      3'd3: begin d = {4'b0, evt_m}; evt_m = 4'b0; end
      3'd4: d = {6'b0, busy_m, disp_en_m};
      default: d = 8'h00;
    endcase
  endtask

  // driver tasks
  task automatic io_write(input logic [7:0] a, input logic [7:0] d, input logic io);
    @(negedge clk);
    addr_bus = a; mem_io = io; c_ri = 1'b1; tb_bus = d; tb_drv = 1'b1; mem_clk = 1'b0;
    @(negedge clk);
    mem_clk = 1'b1;
    @(negedge clk);
    mem_clk = 1'b0; c_ri = 1'b0; mem_io = 1'b0; tb_drv = 1'b0;
  endtask

  task automatic io_read(input logic [7:0] a, output logic [7:0] d);
    @(negedge clk);
    addr_bus = a; mem_io = 1'b1; c_ro = 1'b1; mem_clk = 1'b0;
    #1 d = bus;
    @(negedge clk);
    mem_clk = 1'b1;
    @(negedge clk);
    mem_clk = 1'b0; c_ro = 1'b0; mem_io = 1'b0;
  endtask

  task automatic write_port(input logic [2:0] p, input logic [7:0] d);
    io_write(IO_BASE + {5'b0, p}, d, 1'b1);
    model_write(p, d);
  endtask

  task automatic read_port(input string tag, input logic [2:0] p);
    logic [7:0] e;
    logic [7:0] d;
    model_read(p, e);
    exp_q.push_back(e);
    io_read(IO_BASE + {5'b0, p}, d);
    check(tag, d, exp_q.pop_front());
  endtask

  // bus observed as not driven by the DUT (reads back as z, or 0 in a two-state simulator)
  task automatic check_quiet(input string tag);
    logic q;
    #1 q = ((bus === 8'hzz) || (bus === 8'h00)) ? 1'b1 : 1'b0;
    check(tag, {7'b0, q}, 8'h01);
  endtask

  // scanner model: the first output after reset release appears at cyc 3
  task automatic check_scan(input int n);
    int idx;
    int d;
    int r;
    logic [7:0] onehot;
    logic [7:0] e_row;
    logic [7:0] e_col;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      idx = cyc - 3;
      d = idx % SCAN_DIV;
      r = (idx / SCAN_DIV) % 8;
      onehot = 8'd1 << r;
      if (!disp_en_m || d == 0) begin
        e_row = 8'hFF; e_col = 8'h00;
      end else begin
        e_row = ~onehot; e_col = fb_m[r];
      end
      check("scan_row_n", row_n, e_row);
      check("scan_col", col, e_col);
    end
  endtask

  task automatic readback_fb();
    for (int r = 0; r < 8; r++) begin
      write_port(3'd0, 8'(r));
      read_port("fb_rd", 3'd1);
      read_port("ptr_rd", 3'd0);
    end
  endtask

  // press button i for hold clks, then release and let it settle
  task automatic press(input int i, input int hold, input logic chk_lvl);
    btn[i] = 1'b1;
    repeat (hold) @(negedge clk);
    if (hold >= DEBOUNCE + 4) begin
      lvl_m[i] = 1'b1;
      evt_m[i] = 1'b1;
    end
    if (chk_lvl) read_port("btn_level_held", 3'd2);
    btn[i] = 1'b0;
    repeat (DEBOUNCE + 8) @(negedge clk);
    lvl_m[i] = 1'b0;
  endtask

  // stimulus
  initial begin
    logic [7:0] d;
    reset = 1'b0; addr_bus = 8'h00; c_ri = 1'b0; c_ro = 1'b0; mem_clk = 1'b0;
    mem_io = 1'b0; btn = 4'b0; tb_bus = 8'h00; tb_drv = 1'b0;
    model_reset();

    // reset state and no-drive during reset
    repeat (4) @(negedge clk);
    check("rst_row_n", row_n, 8'hFF);
    check("rst_col", col, 8'h00);
    addr_bus = IO_BASE + 8'd4; mem_io = 1'b1; c_ro = 1'b1;
    check_quiet("rst_bus_quiet");
    mem_io = 1'b0; c_ro = 1'b0;
    @(negedge clk); reset = 1'b1;
    repeat (4) @(negedge clk);
    check("post_rst_row_n", row_n, 8'hFF);
    check("post_rst_col", col, 8'h00);
    read_port("rst_p0", 3'd0);
    read_port("rst_p2", 3'd2);
    read_port("rst_p3", 3'd3);
    read_port("rst_p4", 3'd4);

    // no-drive and ignored cycles with a nonzero row selected
    write_port(3'd0, 8'h03);
    write_port(3'd1, 8'h3C);
    write_port(3'd0, 8'h03);
    @(negedge clk); addr_bus = IO_BASE + 8'd1; mem_io = 1'b0; c_ro = 1'b1;
    check_quiet("nodrive_memio0");
    addr_bus = 8'h12; mem_io = 1'b0;
    check_quiet("nodrive_memio0_p2");
    addr_bus = IO_BASE + 8'd5; mem_io = 1'b1;
    check_quiet("nodrive_above");
    addr_bus = IO_BASE - 8'd1;
    check_quiet("nodrive_below");
    c_ro = 1'b0; mem_io = 1'b0;
    read_port("sel_p1", 3'd1);
    io_write(IO_BASE + 8'd1, 8'hEE, 1'b0);
    read_port("memwr_ignored_fb", 3'd1);
    read_port("memwr_ignored_ptr", 3'd0);

    // random framebuffer writes with occasional row selects
    for (int k = 0; k < 16; k++) begin
      if ($urandom_range(0, 3) == 0) write_port(3'd0, 8'($urandom_range(0, 255)));
      write_port(3'd1, 8'($urandom_range(0, 255)));
    end
    readback_fb();

    // row write with auto-increment and 7 -> 0 wrap
    write_port(3'd0, 8'h07);
    write_port(3'd1, 8'hAA);
    write_port(3'd1, 8'h55);
    read_port("autoinc_ptr", 3'd0);
    write_port(3'd0, 8'h07);
    read_port("fb7", 3'd1);
    write_port(3'd0, 8'h00);
    read_port("fb0", 3'd1);

    // scanning with display enabled, then disabled
    write_port(3'd4, 8'h01);
    @(negedge clk);
    check_scan(72);
    write_port(3'd4, 8'h00);
    @(negedge clk);
    check_scan(12);
    write_port(3'd4, 8'h01);

    // clear sweep; a row write during it is dropped
    io_write(IO_BASE + 8'd4, 8'h03, 1'b1);
    busy_m = 1'b1;
    disp_en_m = 1'b1;
    read_port("clr_busy", 3'd4);
    io_write(IO_BASE + 8'd1, 8'hFF, 1'b1);
    repeat (8) @(negedge clk);
    model_write(3'd4, 8'h03);
    busy_m = 1'b0;
    read_port("clr_done", 3'd4);
    read_port("clr_ptr", 3'd0);
    readback_fb();

    // debounce: short glitch ignored, long hold accepted
    press(1, 10, 1'b1);
    read_port("glitch_evt", 3'd3);
    btn[1] = 1'b1;
    repeat (20) @(negedge clk);
    lvl_m[1] = 1'b1; evt_m[1] = 1'b1;
    read_port("hold_level", 3'd2);
    read_port("hold_evt", 3'd3);
    read_port("hold_evt_cleared", 3'd3);
    btn[1] = 1'b0;
    repeat (DEBOUNCE + 8) @(negedge clk);
    lvl_m[1] = 1'b0;
    read_port("release_level", 3'd2);

    // randomized presses against the event model
    for (int t = 0; t < 12; t++) begin
      int i;
      int l;
      i = $urandom_range(0, 3);
      l = ($urandom_range(0, 1) == 1) ? $urandom_range(22, 40) : $urandom_range(1, 12);
      press(i, l, 1'b1);
      if ($urandom_range(0, 2) == 0) read_port("rand_evt", 3'd3);
    end
    read_port("rand_evt_final", 3'd3);
    read_port("rand_level_final", 3'd2);

    // event collision: btn[0] accepted on the same clk as a read-clear
    press(2, 25, 1'b0);
    @(negedge clk); btn[0] = 1'b1;
    repeat (15) @(negedge clk);
    @(negedge clk);
    addr_bus = IO_BASE + 8'd3; mem_io = 1'b1; c_ro = 1'b1; mem_clk = 1'b0;
    #1 d = bus;
    check("collide_read", d, 8'h04);
    @(negedge clk); mem_clk = 1'b1;
    @(negedge clk); mem_clk = 1'b0; c_ro = 1'b0; mem_io = 1'b0;
    evt_m = 4'b0001; lvl_m[0] = 1'b1;
    read_port("collide_after", 3'd3);
    read_port("collide_cleared", 3'd3);
    btn[0] = 1'b0;
    repeat (DEBOUNCE + 8) @(negedge clk);
    lvl_m[0] = 1'b0;

    // reset in the middle of a clear aborts it
    write_port(3'd0, 8'h02);
    write_port(3'd1, 8'hC3);
    io_write(IO_BASE + 8'd4, 8'h03, 1'b1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("midclr_rst_row_n", row_n, 8'hFF);
    check("midclr_rst_col", col, 8'h00);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    model_reset();
    repeat (4) @(negedge clk);
    read_port("midclr_status", 3'd4);
    read_port("midclr_ptr", 3'd0);
    write_port(3'd0, 8'h02);
    read_port("midclr_fb2", 3'd1);
    check_scan(8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
